// File: rtl/universal_shift_register.sv
// ============================================================================
// Module   : universal_shift_register
// Brief    : WIDTH-bit universal shift register (hold / shift / load / rotate)
//            with a saturating shift counter and frame_done flag.
//            Optional rotate via macro USR_ROTATE_EN (undefined: mode 11 = hold).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH+1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] Par_in,
  output logic [WIDTH-1:0] Par_out,
  output logic             ser_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0]       c_MODE_HOLD  = 2'b00;
  localparam logic [1:0]       c_MODE_SHIFT = 2'b01;
  localparam logic [1:0]       c_MODE_LOAD  = 2'b10;
  localparam logic [1:0]       c_MODE_ROT   = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_q_next;
  logic             w_step;

  always_comb begin
    w_q_next = r_q;
    w_step   = 1'b0;
    case (mode)
      c_MODE_HOLD: w_q_next = r_q;
      c_MODE_SHIFT: begin
        w_step   = 1'b1;
        w_q_next = dir ? {ser_in, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ser_in};
      end
      c_MODE_LOAD: w_q_next = Par_in;
`ifdef USR_ROTATE_EN
      c_MODE_ROT: begin
        w_step   = 1'b1;
        w_q_next = dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      end
`endif
      default: w_q_next = r_q;
    endcase
  end

  // Count saturates at WIDTH; data keeps moving after saturation.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_q   <= RESET_VAL;
      r_cnt <= '0;
    end else begin
      r_q <= w_q_next;
      if (mode == c_MODE_LOAD)
        r_cnt <= '0;
      else if (w_step && (r_cnt != c_CNT_MAX))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign Par_out    = r_q;
  assign ser_out    = dir ? r_q[0] : r_q[WIDTH-1];
  assign shift_cnt  = r_cnt;
  assign frame_done = (r_cnt == c_CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register: table-driven vectors on WIDTH=8,
// hand-written async-reset and WIDTH=4/16 sweep sequences.
`timescale 1ns/100ps
`default_nettype none

module tb_universal_shift_register;

  typedef struct {
    logic [1:0] mode;
    logic       dir;
    logic       ser_in;
    logic [7:0] par_in;
    logic       exp_ser_pre;
    logic [7:0] exp_par;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        dir = 1'b0;
  logic        ser_in = 1'b0;
  logic [7:0]  par_in = 8'h00;
  logic [7:0]  par_out;
  logic        ser_out;
  logic [3:0]  cnt;
  logic        done;

  logic [1:0]  s_mode = 2'b00;
  logic        s_ser = 1'b0;
  logic [3:0]  p4_in = 4'h0;
  logic [3:0]  p4_out;
  logic        s4_out;
  logic [2:0]  c4;
  logic        d4;
  logic [15:0] p16_in = 16'h0;
  logic [15:0] p16_out;
  logic        s16_out;
  logic [4:0]  c16;
  logic        d16;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .reset(rst), .mode(mode), .dir(dir), .ser_in(ser_in),
    .Par_in(par_in), .Par_out(par_out), .ser_out(ser_out),
    .shift_cnt(cnt), .frame_done(done)
  );

  universal_shift_register #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .reset(rst), .mode(s_mode), .dir(1'b0), .ser_in(s_ser),
    .Par_in(p4_in), .Par_out(p4_out), .ser_out(s4_out),
    .shift_cnt(c4), .frame_done(d4)
  );

  universal_shift_register #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .reset(rst), .mode(s_mode), .dir(1'b0), .ser_in(s_ser),
    .Par_in(p16_in), .Par_out(p16_out), .ser_out(s16_out),
    .shift_cnt(c16), .frame_done(d16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic d, input logic s, input logic [7:0] p,
                     input logic sp, input logic [7:0] ep, input logic [3:0] ec, input logic ed);
    vec_t v;
    v.mode = m; v.dir = d; v.ser_in = s; v.par_in = p;
    v.exp_ser_pre = sp; v.exp_par = ep; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic step8(input logic [1:0] m, input logic d, input logic s, input logic [7:0] p);
    @(negedge clk);
    mode = m; dir = d; ser_in = s; par_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ex_sl [8];
    logic [7:0] ex_sr [8];
    logic [7:0] sl_init;
    logic [7:0] sr_init;
    sl_init = 8'hAB;
    sr_init = 8'hD9;

    // Left shifts of AB with ser_in=1, right shifts of D9 with ser_in=0.
    add(2'b10, 1'b0, 1'b0, 8'hAB, 1'b0, 8'hAB, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ex_sl[i] = (i == 0) ? {sl_init[6:0], 1'b1} : {ex_sl[i-1][6:0], 1'b1};
      add(2'b01, 1'b0, 1'b1, 8'h00, (i == 0) ? sl_init[7] : ex_sl[i-1][7],
          ex_sl[i], 4'(i + 1), (i == 7));
    end
    add(2'b10, 1'b1, 1'b0, 8'hD9, 1'b1, 8'hD9, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ex_sr[i] = (i == 0) ? {1'b0, sr_init[7:1]} : {1'b0, ex_sr[i-1][7:1]};
      add(2'b01, 1'b1, 1'b0, 8'h00, (i == 0) ? sr_init[0] : ex_sr[i-1][0],
          ex_sr[i], 4'(i + 1), (i == 7));
    end
    add(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd8, 1'b1);
    // Load directly after frame_done starts a fresh frame.
    add(2'b10, 1'b0, 1'b0, 8'h81, 1'b0, 8'h81, 4'd0, 1'b0);
`ifdef USR_ROTATE_EN
    add(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 4'd1, 1'b0);
    add(2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81, 4'd2, 1'b0);
    add(2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC0, 4'd3, 1'b0);
`else
    add(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81, 4'd0, 1'b0);
    add(2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81, 4'd0, 1'b0);
    add(2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81, 4'd0, 1'b0);
`endif
    add(2'b10, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h5A, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(2'b00, 1'(~i[0]), 1'(~i[0]), 8'hFF, 1'b0, 8'h5A, 4'd0, 1'b0);

    // Reset state
    #2;
    chk("reset_par", 32'(par_out), 32'h00);
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ser", 32'(ser_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      mode = vecs[i].mode; dir = vecs[i].dir; ser_in = vecs[i].ser_in; par_in = vecs[i].par_in;
      #1;
      chk($sformatf("v%0d_ser_pre", i), 32'(ser_out), 32'(vecs[i].exp_ser_pre));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_par", i), 32'(par_out), 32'(vecs[i].exp_par));
      chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end

    // Asynchronous reset mid-frame
    step8(2'b10, 1'b0, 1'b0, 8'hF0);
    step8(2'b01, 1'b0, 1'b0, 8'h00);
    step8(2'b01, 1'b0, 1'b0, 8'h00);
    step8(2'b01, 1'b0, 1'b0, 8'h00);
    chk("pre_rst_par", 32'(par_out), 32'h80);
    chk("pre_rst_cnt", 32'(cnt), 32'd3);
    @(negedge clk);
    mode = 2'b00;
    #2;
    rst = 1'b1;
    #0.5;
    chk("async_rst_par", 32'(par_out), 32'h00);
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    #0.5;
    rst = 1'b0;
    step8(2'b01, 1'b0, 1'b1, 8'h00);
    chk("post_rst_par", 32'(par_out), 32'h01);
    chk("post_rst_cnt", 32'(cnt), 32'd1);

    // WIDTH=4 and WIDTH=16 sweep: load ones, shift in zeros
    @(negedge clk);
    s_mode = 2'b10; p4_in = 4'hF; p16_in = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("w4_load", 32'(p4_out), 32'hF);
    chk("w16_load", 32'(p16_out), 32'hFFFF);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      s_mode = 2'b01; s_ser = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("w4_done_k%0d", k), 32'(d4), 32'(k >= 4));
      chk($sformatf("w16_done_k%0d", k), 32'(d16), 32'(k >= 16));
      if (k == 4) begin
        chk("w4_par", 32'(p4_out), 32'h0);
        chk("w4_cnt", 32'(c4), 32'd4);
      end
    end
    chk("w4_cnt_sat", 32'(c4), 32'd4);
    chk("w16_par", 32'(p16_out), 32'h0);
    chk("w16_cnt", 32'(c16), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the team's 8-bit serial/parallel shift register: a WIDTH-bit universal shift register with parallel load, hold, bidirectional shift and optional rotate. A shift counter raises `frame_done` after WIDTH shift/rotate operations. It serves as the serializer/deserializer stage for the UART-style and datapath exercises, replacing the fixed 8-bit block.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `RESET_VAL`, `'0`, value loaded into the register on reset
- `CNT_W`, `$clog2(WIDTH+1)`, shift-counter width (derived; do not override)

- `Clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `mode`  in  2  00 hold, 01 shift, 10 parallel load, 11 rotate
- `dir`  in  1  0 = shift/rotate toward MSB (left), 1 = toward LSB (right)
- `ser_in`  in  1  serial input bit
- `Par_in`  in  WIDTH  parallel load data
- `Par_out`  out  WIDTH  register contents
- `ser_out`  out  1  serial output bit
- `shift_cnt`  out  CNT_W  shift/rotate operations since the last load or reset
- `frame_done`  out  1  high while `shift_cnt == WIDTH`

One clock; reset is asynchronous and active-high.

## Operation
- Register `q[WIDTH-1:0]` drives `Par_out`.
- Hold (00): `q` and `shift_cnt` unchanged.
- Load (10): `q <= Par_in`; `shift_cnt <= 0`.
- Shift left (01, dir=0): `q <= {q[WIDTH-2:0], ser_in}`.
- Shift right (01, dir=1): `q <= {ser_in, q[WIDTH-1:1]}`.
- Rotate left (11, dir=0): `q <= {q[WIDTH-2:0], q[WIDTH-1]}`; rotate right: `q <= {q[0], q[WIDTH-1:1]}`.
- `ser_out` is combinational: `q[WIDTH-1]` when dir=0, `q[0]` when dir=1. It shows the bit leaving on the next shift.
- Counter: each shift or rotate increments `shift_cnt`, saturating at WIDTH. A shift at saturation still moves data; the count stays at WIDTH.
- `frame_done` is a level derived from `shift_cnt`. It stays high until a load or reset.
- `mode` is a single encoded field, so operations cannot conflict. `dir` is ignored for hold and load.

## Timing
- All state updates on the rising edge of `Clk`. No output latency beyond one register stage.
- `ser_out` and `frame_done` change in the same cycle as `q`/`shift_cnt`, with no extra delay.
- Reset, asynchronous and effective immediately: `q = RESET_VAL`, `Par_out = RESET_VAL`, `shift_cnt = 0`, `frame_done = 0`. `ser_out` follows `RESET_VAL` and `dir`.
- Reset deassertion is taken synchronously at the next edge. The first operation happens on the first rising edge with `reset` low.
- Reset mid-frame discards the partial frame and clears the count. No done indication is produced.
- Load in the cycle after `frame_done` clears the count and starts a new frame with no idle cycle.
- Inputs must be stable around the rising edge. The block applies no input synchronisation.

## Configuration
- `USR_ROTATE_EN` defined: mode 11 rotates as described and increments `shift_cnt`.
- Not defined: mode 11 is treated as hold. `q` and `shift_cnt` are unchanged and no rotate logic is synthesised.
- All other behaviour is identical in both builds.

## Test plan
- WIDTH=8. Load 8'hAB, then 8 left shifts with `ser_in=1` -> `ser_out` before each edge reads 1,0,1,0,1,0,1,1. Final `Par_out=8'hFF`, `shift_cnt=8`, `frame_done=1`.
- Load 8'hD9, then 8 right shifts with `ser_in=0` -> `ser_out` reads 1,0,0,1,1,0,1,1. Final `Par_out=8'h00`, `frame_done=1`. A 9th shift keeps `shift_cnt=8`.
- With `USR_ROTATE_EN`: load 8'h81, rotate left once -> 8'h03; rotate right twice -> 8'hC0, `shift_cnt=3`. Without the macro, mode 11 leaves 8'h81 and `shift_cnt=0`.
- Hold: load 8'h5A, apply mode 00 for 5 cycles while toggling `ser_in`/`dir` -> `Par_out=8'h5A`, `shift_cnt=0`.
- Reset mid-frame: load 8'hF0 and shift left 3 times, then pulse `reset` for 1 ns between edges -> immediately `Par_out=RESET_VAL (8'h00)`, `shift_cnt=0`, `frame_done=0`.
- Parameter sweep: WIDTH=4 and WIDTH=16. Load all-ones and shift in zeros WIDTH times -> all-zero register. `frame_done` rises exactly on the WIDTH-th shift.
